// File: rtl/poly_stream_reader.sv
// Streams 32*num_polys RAM words out of ram_96x256 as 12-bit coefficients over valid/ready.
// Optional CANON_REDUCE_EN: reduce each coefficient c to (c>=3329) ? c-3329 : c on output.
module poly_stream_reader #(
    parameter int DATA_W         = 96,
    parameter int COEF_W         = 12,
    parameter int COEFS_PER_WORD = 8,
    parameter int ADDR_W         = 8,
    parameter int WORDS_PER_POLY = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_offset,
    input  logic [1:0]        num_polys,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_last
);
    // Handshake: a coefficient transfers on any rising edge where coef_valid && coef_ready;
    // while coef_valid && !coef_ready, coef_data and coef_last stay unchanged.

    localparam int LANE_W = $clog2(COEFS_PER_WORD);
    localparam int IDX_W  = $clog2(WORDS_PER_POLY * COEFS_PER_WORD);
    localparam int CNT_W  = $clog2(3 * WORDS_PER_POLY + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   raddr_q;
    logic [CNT_W-1:0]    issue_left_q;
    logic                iss_q;
    logic                dat_q;
    logic [DATA_W-1:0]   cur_word_q;
    logic                cur_valid_q;
    logic [DATA_W-1:0]   pref_word_q;
    logic                pref_valid_q;
    logic [IDX_W-1:0]    coef_idx_q;
    logic [1:0]          polys_left_q;

    logic                start_go;
    logic                launch;
    logic                issue;
    logic                xfer;
    logic                word_end;
    logic                final_xfer;
    logic [CNT_W-1:0]    words_total;
    logic [COEF_W-1:0]   raw_coef;
    logic [COEF_W-1:0]   out_coef;

    assign start_go    = (state_q == IDLE) && start;
    assign launch      = start_go && (num_polys != 2'd0);
    assign words_total = CNT_W'(num_polys) * CNT_W'(WORDS_PER_POLY);
    assign xfer        = cur_valid_q && coef_ready;
    assign word_end    = xfer && (coef_idx_q[LANE_W-1:0] == LANE_W'(COEFS_PER_WORD - 1));
    assign final_xfer  = xfer && (coef_idx_q == '1) && (polys_left_q == 2'd1);

    // One read in flight at a time, and only into an empty prefetch slot; a word lasts
    // eight transfers, which hides the two-cycle read latency at full throughput.
    assign issue = ((state_q == PRIME) || (state_q == STREAM)) && (issue_left_q != '0)
                   && !iss_q && !dat_q && !pref_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_polys == 2'd0) ? FINISH : PRIME;
            PRIME:   if (dat_q) state_d = STREAM;
            STREAM:  if (final_xfer) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            raddr_q      <= '0;
            issue_left_q <= '0;
            iss_q        <= 1'b0;
            dat_q        <= 1'b0;
            cur_word_q   <= '0;
            cur_valid_q  <= 1'b0;
            pref_word_q  <= '0;
            pref_valid_q <= 1'b0;
            coef_idx_q   <= '0;
            polys_left_q <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= launch || issue;
            dat_q   <= iss_q;

            if (launch) begin
                raddr_q      <= start_offset;
                issue_left_q <= words_total - CNT_W'(1);
            end else if (issue) begin
                raddr_q      <= raddr_q + ADDR_W'(1);
                issue_left_q <= issue_left_q - CNT_W'(1);
            end

            if (start_go) begin
                polys_left_q <= num_polys;
                coef_idx_q   <= '0;
            end else if (xfer) begin
                coef_idx_q <= coef_idx_q + IDX_W'(1);
                if (coef_idx_q == '1) polys_left_q <= polys_left_q - 2'd1;
            end

            // Returning data always finds the prefetch slot empty, so it lands in the
            // current-word register when that is free or draining, else in the prefetch.
            if (word_end) begin
                if (pref_valid_q) begin
                    cur_word_q   <= pref_word_q;
                    pref_valid_q <= 1'b0;
                end else if (dat_q) begin
                    cur_word_q <= ram_rdata;
                end else begin
                    cur_valid_q <= 1'b0;
                end
            end else if (dat_q) begin
                if (cur_valid_q) begin
                    pref_word_q  <= ram_rdata;
                    pref_valid_q <= 1'b1;
                end else begin
                    cur_word_q  <= ram_rdata;
                    cur_valid_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        raw_coef = '0;
        for (int k = 0; k < COEFS_PER_WORD; k++) begin
            if (coef_idx_q[LANE_W-1:0] == LANE_W'(k)) raw_coef = cur_word_q[k*COEF_W +: COEF_W];
        end
    end

`ifdef CANON_REDUCE_EN
    assign out_coef = (raw_coef >= COEF_W'(3329)) ? raw_coef - COEF_W'(3329) : raw_coef;
`else
    assign out_coef = raw_coef;
`endif

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);
    assign ram_raddr  = raddr_q;
    assign coef_valid = cur_valid_q;
    assign coef_data  = cur_valid_q ? out_coef : '0;
    assign coef_last  = cur_valid_q && (coef_idx_q == '1);

endmodule

// File: tb/tb_poly_stream_reader.sv
// Bench for poly_stream_reader: RAM model, directed runs with random data/backpressure,
// expected-coefficient queue built from the RAM image, immediate-assertion checks.
module tb_poly_stream_reader;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  start_offset;
    logic [1:0]  num_polys;
    logic        busy;
    logic        done;
    logic [7:0]  ram_raddr;
    logic [95:0] ram_rdata;
    logic        coef_valid;
    logic        coef_ready;
    logic [11:0] coef_data;
    logic        coef_last;

    logic [95:0] mem [256];
    logic [11:0] exp_q[$];
    int          checks;
    int          failures;

`ifdef CANON_REDUCE_EN
    localparam logic [11:0] SPOT_EXP = 12'd71;
`else
    localparam logic [11:0] SPOT_EXP = 12'd3400;
`endif

    poly_stream_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_offset (start_offset),
        .num_polys    (num_polys),
        .busy         (busy),
        .done         (done),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .coef_valid   (coef_valid),
        .coef_ready   (coef_ready),
        .coef_data    (coef_data),
        .coef_last    (coef_last)
    );

    // clock / RAM model: data shows up the cycle after the address is presented
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial ram_rdata = '0;
    always @(posedge clk) ram_rdata <= mem[ram_raddr];

    function automatic logic [11:0] ref_coef(input logic [11:0] c);
`ifdef CANON_REDUCE_EN
        return (c >= 12'd3329) ? c - 12'd3329 : c;
`else
        return c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_linear(input logic [7:0] off, input int nwords);
        logic [7:0] a;
        for (int i = 0; i < nwords; i++) begin
            a = off + 8'(i);
            for (int j = 0; j < 8; j++) mem[a][12*j +: 12] = 12'(8*i + j);
        end
    endtask

    task automatic fill_random(input logic [7:0] off, input int nwords);
        logic [7:0] a;
        for (int i = 0; i < nwords; i++) begin
            a = off + 8'(i);
            for (int j = 0; j < 8; j++) mem[a][12*j +: 12] = 12'($urandom_range(4095));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ":busy"}, 32'(busy), 32'(0));
        chk({tag, ":done"}, 32'(done), 32'(0));
        chk({tag, ":coef_valid"}, 32'(coef_valid), 32'(0));
        chk({tag, ":coef_last"}, 32'(coef_last), 32'(0));
        chk({tag, ":ram_raddr"}, 32'(ram_raddr), 32'(0));
        chk({tag, ":coef_data"}, 32'(coef_data), 32'(0));
    endtask

    // One start/stream/done episode. abort_at>=0 pulls reset when that coefficient is shown.
    task automatic run_stream(input string name, input logic [7:0] off, input logic [1:0] n,
                              input int ready_pct, input int abort_at, input int spot_idx);
        int          total, got, cyc, done_cyc, naddr;
        logic [7:0]  a, last_addr, nxt;
        logic [95:0] w;
        logic        stall, hold_last, finished;
        logic [11:0] hold_data;

        total = 256 * int'(n);
        exp_q.delete();
        for (int i = 0; i < 32 * int'(n); i++) begin
            a = off + 8'(i);
            w = mem[a];
            for (int j = 0; j < 8; j++) exp_q.push_back(ref_coef(w[12*j +: 12]));
        end

        start = 1'b1; start_offset = off; num_polys = n; coef_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; start_offset = 8'($urandom); num_polys = 2'($urandom);
        cyc = 1; got = 0; done_cyc = -1; naddr = 0; stall = 1'b0; finished = 1'b0;
        last_addr = off; hold_data = '0; hold_last = 1'b0;
        if (n != 2'd0) begin
            chk({name, ":raddr_first"}, 32'(ram_raddr), 32'(off));
            naddr = 1;
        end

        while (!finished && cyc < total * 8 + 64) begin
            coef_ready = ($urandom_range(99) < ready_pct);
            start = (cyc == 40);
            if (abort_at >= 0 && got == abort_at && coef_valid) begin
                rst = 1'b0;
                @(posedge clk); #1;
                check_idle_outputs({name, ":abort"});
                rst = 1'b1; start = 1'b0; coef_ready = 1'b0;
                exp_q.delete();
                return;
            end
            chk({name, ":busy"}, 32'(busy), 32'(1));
            if (n != 2'd0 && ram_raddr !== last_addr) begin
                nxt = last_addr + 8'd1;
                chk({name, ":raddr_step"}, 32'(ram_raddr), 32'(nxt));
                last_addr = ram_raddr;
                naddr++;
            end
            if (cyc < 3)
                chk({name, ":latency_valid"}, 32'(coef_valid), 32'(0));
            else if (ready_pct == 100 && got < total)
                chk({name, ":no_bubble"}, 32'(coef_valid), 32'(1));
            if (stall) begin
                chk({name, ":stall_valid"}, 32'(coef_valid), 32'(1));
                chk({name, ":stall_data"}, 32'(coef_data), 32'(hold_data));
                chk({name, ":stall_last"}, 32'(coef_last), 32'(hold_last));
            end
            if (coef_valid) begin
                if (exp_q.size() == 0) begin
                    chk({name, ":extra_coef"}, 32'(exp_q.size()), 32'(1));
                end else begin
                    chk({name, ":data"}, 32'(coef_data), 32'(exp_q[0]));
                    chk({name, ":last"}, 32'(coef_last), 32'((got % 256) == 255));
                    if (got == spot_idx) chk({name, ":canon_3400"}, 32'(coef_data), 32'(SPOT_EXP));
                    if (coef_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
                stall = !coef_ready; hold_data = coef_data; hold_last = coef_last;
            end else begin
                stall = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; coef_ready = 1'b0;

        if (!finished) begin
            chk({name, ":done_seen"}, 32'(finished), 32'(1));
        end else begin
            chk({name, ":count"}, 32'(got), 32'(total));
            if (ready_pct == 100)
                chk({name, ":done_cycle"}, 32'(done_cyc), (n == 2'd0) ? 32'(1) : 32'(3 + total));
            chk({name, ":done_pulse"}, 32'(done), 32'(0));
            chk({name, ":idle_busy"}, 32'(busy), 32'(0));
            chk({name, ":idle_valid"}, 32'(coef_valid), 32'(0));
            if (n != 2'd0) chk({name, ":raddr_count"}, 32'(naddr), 32'(32 * int'(n)));
        end
    endtask

    initial begin
        logic [7:0] off;
        checks = 0; failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b0; start = 1'b0; start_offset = '0; num_polys = '0; coef_ready = 1'b0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // T1: ascending coefficients at full rate
        fill_linear(8'h10, 32);
        run_stream("t1", 8'h10, 2'd1, 100, -1, -1);

        // T2: same stream with 50% backpressure
        run_stream("t2", 8'h10, 2'd1, 50, -1, -1);

        // T3: address wrap 0xFF -> 0x00
        fill_random(8'hF0, 32);
        run_stream("t3", 8'hF0, 2'd1, 100, -1, -1);

        // T4: three polynomials back to back
        fill_linear(8'h37, 96);
        run_stream("t4", 8'h37, 2'd3, 100, -1, -1);
        off = 8'($urandom);
        fill_random(off, 64);
        run_stream("t4r", off, 2'd2, 60, -1, -1);

        // T5: zero polynomials
        run_stream("t5", 8'h22, 2'd0, 100, -1, -1);

        // T6: reset mid-stream, then a fresh start; coefficient #5 holds 3400
        off = 8'h80;
        fill_random(off, 32);
        mem[off][5*12 +: 12] = 12'd3400;
        run_stream("t6", off, 2'd1, 100, 100, 5);
        @(posedge clk); #1;
        check_idle_outputs("t6_idle");
        fill_linear(8'h10, 32);
        run_stream("t6_restart", 8'h10, 2'd1, 100, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
